// File: rtl/eth_pkg.sv
// eth_pkg: shared constants and state encoding for the Ethernet/IPv4/UDP/MoldUDP64 framer.
package eth_pkg;
    localparam int ETH_LEN    = 14;
    localparam int IP_LEN     = 20;
    localparam int UDP_LEN    = 8;
    localparam int MOLD_LEN   = 20;
    localparam int MSGLEN_LEN = 2;
    localparam int HDR_LEN    = ETH_LEN + IP_LEN + UDP_LEN + MOLD_LEN + MSGLEN_LEN;
    localparam int GAP_LEN    = 12;
    localparam logic [15:0] ETH_END    = 16'(ETH_LEN - 1);
    localparam logic [15:0] IP_END     = 16'(ETH_LEN + IP_LEN - 1);
    localparam logic [15:0] UDP_END    = 16'(ETH_LEN + IP_LEN + UDP_LEN - 1);
    localparam logic [15:0] MOLD_END   = 16'(ETH_LEN + IP_LEN + UDP_LEN + MOLD_LEN - 1);
    localparam logic [15:0] HDR_END    = 16'(HDR_LEN - 1);
    localparam logic [15:0] GAP_END    = 16'(GAP_LEN - 1);
    localparam logic [15:0] MAX_ITCH_LEN   = 16'd1400;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_TTL         = 8'h01;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    typedef enum logic [2:0] {IDLE, ETH, IP, UDP, MOLD, MSGLEN, PAYLOAD, GAP} state_t;
endpackage

// File: rtl/ip_checksum.sv
// ip_checksum: registered IPv4 header checksum over ten 16-bit words.
module ip_checksum (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0][15:0] words,
    output logic [15:0]      csum
);
    logic [19:0] sum;
    logic [16:0] fold;
    always_comb begin
        sum = '0;
        for (int i = 0; i < 10; i++) sum = sum + {4'b0, words[i]};
    end
    // two end-around folds: the second can only carry a single bit
    assign fold = {1'b0, sum[15:0]} + {13'b0, sum[19:16]};
    always_ff @(posedge clk) begin
        if (rst) csum <= '0;
        else     csum <= ~(fold[15:0] + {15'b0, fold[16]});
    end
endmodule

// File: rtl/eth_udp_framer.sv
// eth_udp_framer: wraps one ITCH message per frame in Ethernet/IPv4/UDP/MoldUDP64 headers.
module eth_udp_framer import eth_pkg::*; #(
    parameter logic [47:0] DST_MAC  = 48'h01005E000001,
    parameter logic [47:0] SRC_MAC  = 48'h020000000001,
    parameter logic [31:0] SRC_IP   = 32'h0A000001,
    parameter logic [31:0] DST_IP   = 32'hE9000001,
    parameter logic [15:0] SRC_PORT = 16'd5000,
    parameter logic [15:0] DST_PORT = 16'd26400,
    parameter logic [79:0] SESSION  = 80'h0
) (
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic        startIn,
    input  logic [15:0] itchLenIn,
    output logic        startReadyOut,
    input  logic [7:0]  itchDataIn,
    input  logic        itchDataValidIn,
    output logic        itchDataReadyOut,
    output logic [7:0]  dataOut,
    output logic        dataValidOut,
    output logic        dataErrOut,
    output logic        dataLastOut
);
    state_t state, state_n;
    logic [15:0] len, pos, pos_n, ident, csum, ip_len, udp_len;
    logic [63:0] seq;
    logic [0:HDR_LEN-1][7:0] hdr;
    logic start_ok, pay_last, good_last;
    assign ip_len  = len + 16'd50;
    assign udp_len = len + 16'd30;
    assign hdr = {DST_MAC, SRC_MAC, ETHERTYPE_IPV4,
                  16'h4500, ip_len, ident, 16'h4000, IP_TTL, IP_PROTO_UDP, csum, SRC_IP, DST_IP,
                  SRC_PORT, DST_PORT, udp_len, 16'h0000,
                  SESSION, seq, 16'h0001,
                  len};
    ip_checksum u_csum (
        .clk  (clkIn),
        .rst  (rstIn),
        .words({16'h4500, ip_len, ident, 16'h4000, IP_TTL, IP_PROTO_UDP, 16'h0000, SRC_IP, DST_IP}),
        .csum (csum)
    );
    assign start_ok  = startIn && state == IDLE && itchLenIn != 16'd0 && itchLenIn <= MAX_ITCH_LEN;
    assign pay_last  = pos == len + HDR_END;
    assign good_last = state == PAYLOAD && itchDataValidIn && pay_last;
    // pos is the byte offset within the frame; GAP reuses it as an idle-cycle counter
    always_comb begin
        state_n = state;
        pos_n   = pos + 16'd1;
        case (state)
            IDLE: begin
                pos_n   = '0;
                state_n = start_ok ? ETH : IDLE;
            end
            ETH:     state_n = pos == ETH_END  ? IP      : ETH;
            IP:      state_n = pos == IP_END   ? UDP     : IP;
            UDP:     state_n = pos == UDP_END  ? MOLD    : UDP;
            MOLD:    state_n = pos == MOLD_END ? MSGLEN  : MOLD;
            MSGLEN:  state_n = pos == HDR_END  ? PAYLOAD : MSGLEN;
            PAYLOAD: if (!itchDataValidIn || pay_last) begin
                state_n = GAP;
                pos_n   = '0;
            end
            GAP:     state_n = pos == GAP_END  ? IDLE    : GAP;
            default: state_n = IDLE;
        endcase
    end
    assign startReadyOut    = state == IDLE;
    assign itchDataReadyOut = state == PAYLOAD;
    assign dataValidOut     = state != IDLE && state != GAP;
    assign dataErrOut       = state == PAYLOAD && !itchDataValidIn;
    assign dataLastOut      = state == PAYLOAD && (!itchDataValidIn || pay_last);
    assign dataOut = state == PAYLOAD ? (itchDataValidIn ? itchDataIn : 8'h00)
                   : dataValidOut ? hdr[pos[5:0]] : 8'h00;
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state <= IDLE;
            pos   <= '0;
            len   <= '0;
            seq   <= 64'd1;
            ident <= '0;
        end else begin
            state <= state_n;
            pos   <= pos_n;
            if (start_ok) len <= itchLenIn;
            if (good_last) begin
                seq   <= seq + 64'd1;
                ident <= ident + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_eth_udp_framer.sv
// tb_eth_udp_framer: directed frames with hand-computed checksums, underrun, reset abort, illegal lengths.
module tb_eth_udp_framer;
    logic        clk = 1'b0;
    logic        rstIn = 1'b1, startIn = 1'b0, itchDataValidIn = 1'b0;
    logic [15:0] itchLenIn = '0;
    logic [7:0]  itchDataIn = '0;
    logic        startReadyOut, itchDataReadyOut, dataValidOut, dataErrOut, dataLastOut;
    logic [7:0]  dataOut;
    int total = 0, bad = 0, nb;
    always #5 clk = ~clk;

    eth_udp_framer dut (
        .clkIn(clk), .rstIn(rstIn), .startIn(startIn), .itchLenIn(itchLenIn),
        .startReadyOut(startReadyOut), .itchDataIn(itchDataIn),
        .itchDataValidIn(itchDataValidIn), .itchDataReadyOut(itchDataReadyOut),
        .dataOut(dataOut), .dataValidOut(dataValidOut), .dataErrOut(dataErrOut),
        .dataLastOut(dataLastOut)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // expected header from the default parameters; checksum is supplied hand-computed
    function automatic logic [7:0] exp_hdr(input int i, input logic [15:0] n, input logic [63:0] seq,
                                           input logic [15:0] id, input logic [15:0] cs);
        logic [0:63][7:0] h;
        h = {48'h01005E000001, 48'h020000000001, 16'h0800,
             16'h4500, n + 16'd50, id, 16'h4000, 16'h0111, cs, 32'h0A000001, 32'hE9000001,
             16'd5000, 16'd26400, n + 16'd30, 16'h0000,
             80'h0, seq, 16'h0001, n};
        return h[i];
    endfunction

    // called at a negedge; returns at the negedge following the frame's final (or aborting) byte
    task automatic run_frame(input int n, input int drop_at, input int abort_at, input logic [63:0] seq,
                             input logic [15:0] id, input logic [15:0] cs, output int nbytes);
        int k = 0, cnt = 0;
        bit done = 0, err_e, last_e;
        logic [7:0] b_e;
        startIn = 1'b1;
        itchLenIn = n[15:0];
        @(negedge clk);
        startIn = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            itchDataValidIn = itchDataReadyOut && k != drop_at;
            itchDataIn = k[7:0];
            #1;
            check($sformatf("valid[%0d]", cnt), dataValidOut, 1'b1);
            if (!dataValidOut) done = 1;
            else begin
                err_e  = cnt >= 64 && cnt - 64 == drop_at;
                last_e = err_e || cnt == 63 + n;
                b_e    = cnt < 64 ? exp_hdr(cnt, n[15:0], seq, id, cs) : err_e ? 8'h00 : 8'(cnt - 64);
                check($sformatf("byte[%0d]", cnt), dataOut, b_e);
                check($sformatf("err[%0d]", cnt), dataErrOut, err_e);
                check($sformatf("last[%0d]", cnt), dataLastOut, last_e);
                if (dataLastOut) done = 1;
                if (cnt == abort_at) begin
                    rstIn = 1'b1;
                    done = 1;
                end
                cnt++;
            end
            if (itchDataReadyOut && itchDataValidIn) k++;
            @(negedge clk);
        end
        check("frame_timeout", done, 1'b1);
        itchDataValidIn = 1'b0;
        nbytes = cnt;
    endtask

    task automatic measure_gap();
        int g = 0;
        while (!startReadyOut && g < 100) begin
            check("gap_quiet", dataValidOut, 1'b0);
            g++;
            @(negedge clk);
        end
        check("gap_len", g, 12);
    endtask

    task automatic try_illegal(input logic [15:0] n);
        startIn = 1'b1;
        itchLenIn = n;
        @(negedge clk);
        startIn = 1'b0;
        check($sformatf("illegal%0d_ready", n), startReadyOut, 1'b1);
        check($sformatf("illegal%0d_valid", n), dataValidOut, 1'b0);
        @(negedge clk);
        check($sformatf("illegal%0d_valid2", n), dataValidOut, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rstIn = 1'b0;
        check("rst_ready", startReadyOut, 1'b1);
        check("rst_valid", dataValidOut, 1'b0);
        check("rst_err", dataErrOut, 1'b0);
        check("rst_last", dataLastOut, 1'b0);
        check("rst_itch_ready", itchDataReadyOut, 1'b0);
        check("rst_data", dataOut, 8'h00);
        run_frame(133, -1, -1, 64'd1, 16'd0, 16'h8634, nb);
        check("n133_bytes", nb, 197);
        measure_gap();
        run_frame(1, -1, -1, 64'd2, 16'd1, 16'h86B7, nb);
        check("n1_bytes", nb, 65);
        measure_gap();
        try_illegal(16'd0);
        try_illegal(16'd1401);
        run_frame(60, 50, -1, 64'd3, 16'd2, 16'h867B, nb);
        check("underrun_bytes", nb, 115);
        measure_gap();
        run_frame(1, -1, -1, 64'd3, 16'd2, 16'h86B6, nb);
        check("after_underrun_bytes", nb, 65);
        measure_gap();
        run_frame(5, -1, 19, 64'd4, 16'd3, 16'h0000, nb);
        check("abort_bytes", nb, 20);
        check("abort_valid", dataValidOut, 1'b0);
        check("abort_ready", startReadyOut, 1'b1);
        check("abort_last", dataLastOut, 1'b0);
        rstIn = 1'b0;
        @(negedge clk);
        run_frame(1, -1, -1, 64'd1, 16'd0, 16'h86B8, nb);
        check("after_reset_bytes", nb, 65);
        measure_gap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
